// File: rtl/dma_types.sv
// Shared types and constants for the OAM DMA engine.
package dma_types;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RD   = 3'd2,
        WR   = 3'd3,
        FIN  = 3'd4
    } DmaState;

    localparam logic [15:0] OAM_DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE_ADDR    = 16'hFE00;
    localparam int unsigned OAM_DMA_LEN      = 32'd160;

    function automatic logic [15:0] oam_dst_addr(input logic [15:0] base, input logic [7:0] idx);
        return base + {8'h00, idx};
    endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA bus initiator: copies DMA_LEN bytes from {src_hi, idx} to OAM_BASE + idx
// after a CPU write to the trigger register.
module oam_dma
    import dma_types::*;
#(
    parameter logic [15:0] OAM_BASE     = OAM_BASE_ADDR,
    parameter logic [15:0] DMA_REG_ADDR = OAM_DMA_REG_ADDR,
    parameter int unsigned DMA_LEN      = OAM_DMA_LEN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_wr,
    input  logic        reg_rd,
    input  logic [15:0] reg_addr,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    output logic        reg_hit,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [15:0] m_addr,
    output logic        m_rd,
    output logic        m_wr,
    output logic [7:0]  m_wdata,
    input  logic [7:0]  m_rdata,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 32'd1);

    DmaState    r_state;
    DmaState    w_state_next;
    logic [7:0] r_idx;
    logic [7:0] w_idx_next;
    logic [7:0] r_src_hi;
    logic [7:0] r_rdata;
    logic       r_hit;
    logic       w_trig;
    logic       w_rd_hit;
    logic       w_active;

    assign w_trig   = reg_wr && (reg_addr == DMA_REG_ADDR);
    assign w_rd_hit = reg_rd && (reg_addr == DMA_REG_ADDR);
    assign w_active = (r_state == REQ) || (r_state == RD) || (r_state == WR);

    // Trigger register and its readback; a read samples the value before a same-cycle write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_src_hi <= 8'hFF;
            r_rdata  <= 8'hFF;
            r_hit    <= 1'b0;
        end else begin
            r_hit <= w_rd_hit;
            if (w_rd_hit) begin
                r_rdata <= r_src_hi;
            end
            if (w_trig) begin
                r_src_hi <= reg_wdata;
            end
        end
    end

    // State and byte index registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_idx   <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // Next-state logic; losing the grant parks in REQ without advancing idx.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            IDLE: begin
                if (w_trig) begin
                    w_state_next = REQ;
                    w_idx_next   = 8'h00;
                end else begin
                    w_state_next = IDLE;
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    w_state_next = RD;
                end else begin
                    w_state_next = REQ;
                end
            end
            RD: begin
                if (bus_gnt) begin
                    w_state_next = WR;
                end else begin
                    w_state_next = REQ;
                end
            end
            WR: begin
                if (!bus_gnt) begin
                    w_state_next = REQ;
                end else if (r_idx == LAST_IDX) begin
                    w_state_next = FIN;
                end else begin
                    w_state_next = RD;
                    w_idx_next   = r_idx + 8'd1;
                end
            end
            FIN: begin
                if (w_trig) begin
                    w_state_next = REQ;
                    w_idx_next   = 8'h00;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_idx_next   = 8'h00;
            end
        endcase
        // A re-trigger mid-transfer restarts from byte 0 and skips the done pulse.
        if (w_trig && w_active) begin
            w_idx_next   = 8'h00;
            w_state_next = bus_gnt ? RD : REQ;
        end else begin
            w_idx_next   = w_idx_next;
        end
    end

    // Bus outputs decoded from state; strobes are gated by the live grant.
    always_comb begin
        busy    = w_active;
        bus_req = w_active;
        done    = (r_state == FIN);
        m_rd    = 1'b0;
        m_wr    = 1'b0;
        m_addr  = 16'h0000;
        m_wdata = 8'h00;
        case (r_state)
            RD: begin
                m_rd   = bus_gnt;
                m_addr = {r_src_hi, r_idx};
            end
            WR: begin
                m_wr    = bus_gnt;
                m_addr  = oam_dst_addr(OAM_BASE, r_idx);
                m_wdata = m_rdata;
            end
            default: begin
                m_rd = 1'b0;
                m_wr = 1'b0;
            end
        endcase
    end

    assign reg_rdata = r_rdata;
    assign reg_hit   = r_hit;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: register table, timed copy, grant loss,
// re-trigger, mid-transfer reset and randomized grant against a memory model.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_wr, reg_rd;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata, reg_rdata;
    logic        reg_hit, bus_req, bus_gnt;
    logic [15:0] m_addr;
    logic        m_rd, m_wr;
    logic [7:0]  m_wdata, m_rdata;
    logic        busy, done;

    always #5 clk = ~clk;

    oam_dma dut (
        .clk(clk), .reset(reset),
        .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .reg_hit(reg_hit),
        .bus_req(bus_req), .bus_gnt(bus_gnt),
        .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .busy(busy), .done(done)
    );

    // Bus responder model: source memory and OAM image.
    logic [7:0] src_mem [0:65535];
    logic [7:0] oam [0:159];
    logic [7:0] rdata_q = 8'h00;
    logic       clr = 1'b0;
    logic [15:0] rd_tgt = 16'h0000;
    int cyc = 0, n_wr = 0, n_wr_out = 0, n_done = 0, n_viol = 0, n_rd_tgt = 0;
    assign m_rdata = rdata_q;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr) begin
            n_wr <= 0; n_wr_out <= 0; n_done <= 0; n_viol <= 0; n_rd_tgt <= 0;
            for (int i = 0; i < 160; i++) oam[i] <= 8'h5A;
        end else begin
            if (m_rd) rdata_q <= src_mem[m_addr];
            if (m_wr) begin
                n_wr <= n_wr + 1;
                if (m_addr >= 16'hFE00 && m_addr < 16'hFEA0) oam[m_addr[7:0]] <= m_wdata;
                else n_wr_out <= n_wr_out + 1;
            end
            if (done) n_done <= n_done + 1;
            if ((m_rd && m_wr) || ((m_rd || m_wr) && !bus_gnt)) n_viol <= n_viol + 1;
            if (m_rd && m_addr == rd_tgt) n_rd_tgt <= n_rd_tgt + 1;
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = 16'h0000; reg_wdata = 8'h00;
        bus_gnt = 1'b0; clr = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic write_reg(input logic [15:0] a, input logic [7:0] d);
        reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        tick();
        reg_wr = 1'b0;
    endtask

    task automatic fill_src(input logic [7:0] hi);
        for (int i = 0; i < 256; i++) src_mem[{hi, 8'(i)}] = 8'($urandom);
    endtask

    // Reference: OAM byte i must equal source byte {hi, i} for every i below 160.
    task automatic check_oam(input string name, input logic [7:0] hi);
        int bad = 0;
        for (int i = 0; i < 160; i++) if (oam[i] !== src_mem[{hi, 8'(i)}]) bad++;
        chk(name, bad, 0);
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (done) begin at = cyc; break; end
        end
    endtask

    task automatic wait_wr(input logic [15:0] a, input int budget, output bit found);
        found = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (m_wr && m_addr == a) begin found = 1'b1; break; end
        end
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        hit;
        logic [7:0]  rdata;
        logic        busy;
    } vec_t;

    vec_t tbl [9];
    int   n0, first_rd, last_wr, done_at, saved;
    bit   found;
    logic [7:0] hi;

    initial begin
        tbl[0] = '{1'b0, 1'b1, 16'hFF46, 8'h00, 1'b1, 8'hFF, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 16'hFF47, 8'h12, 1'b0, 8'hFF, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 16'hFF46, 8'h00, 1'b1, 8'hFF, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 16'hFF45, 8'h00, 1'b0, 8'hFF, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 16'hFF46, 8'h33, 1'b1, 8'hFF, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 16'hFF46, 8'h00, 1'b1, 8'h33, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 16'hFF46, 8'h00, 1'b0, 8'h33, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 16'hFF46, 8'hAB, 1'b0, 8'h33, 1'b1};
        tbl[8] = '{1'b0, 1'b1, 16'hFF46, 8'h00, 1'b1, 8'hAB, 1'b1};

        // Reset state and register-side table, grant held low.
        do_reset();
        chk("reset_outputs", {bus_req, busy, done, m_rd, m_wr, reg_hit}, 32'h0);
        chk("reset_m_addr", m_addr, 16'h0000);
        chk("reset_rdata", reg_rdata, 8'hFF);
        for (int v = 0; v < 9; v++) begin
            reg_wr = tbl[v].wr; reg_rd = tbl[v].rd; reg_addr = tbl[v].addr; reg_wdata = tbl[v].wdata;
            tick();
            reg_wr = 1'b0; reg_rd = 1'b0;
            chk($sformatf("tbl%0d_hit", v), reg_hit, tbl[v].hit);
            chk($sformatf("tbl%0d_rdata", v), reg_rdata, tbl[v].rdata);
            chk($sformatf("tbl%0d_busy", v), {busy, bus_req}, {tbl[v].busy, tbl[v].busy});
        end
        chk("tbl_no_writes", n_wr, 0);

        // Full copy from 0xC000 with grant always high: check cycle timing.
        do_reset();
        bus_gnt = 1'b1;
        fill_src(8'hC0);
        write_reg(16'hFF46, 8'hC0);
        n0 = cyc;
        chk("trig_req_busy", {bus_req, busy}, 2'b11);
        first_rd = -1; last_wr = -1; done_at = -1;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (m_rd && first_rd < 0) first_rd = cyc;
            if (m_wr) last_wr = cyc;
            if (done) begin done_at = cyc; break; end
        end
        chk("first_rd_cycle", first_rd - n0, 1);
        chk("last_wr_cycle", last_wr - n0, 320);
        chk("done_cycle", done_at - n0, 321);
        chk("done_not_busy", {busy, bus_req}, 2'b00);
        tick();
        chk("done_one_cycle", {done, busy}, 2'b00);
        chk("copy_writes", n_wr, 160);
        chk("copy_done_count", n_done, 1);
        chk("copy_protocol", n_viol, 0);
        check_oam("copy_data", 8'hC0);

        // Grant dropped for 5 cycles during WR of idx 37.
        do_reset();
        bus_gnt = 1'b1;
        fill_src(8'hC0);
        rd_tgt = 16'hC025;
        write_reg(16'hFF46, 8'hC0);
        wait_wr(16'hFE25, 200, found);
        chk("gnt_reach_idx37", found, 1'b1);
        bus_gnt = 1'b0;
        #1;
        chk("gnt_wr_suppressed", {m_wr, m_rd}, 2'b00);
        repeat (5) tick();
        chk("gnt_still_req", {bus_req, m_rd, m_wr}, 3'b100);
        bus_gnt = 1'b1;
        wait_done(400, done_at);
        chk("gnt_done_seen", done_at > 0, 1'b1);
        tick();
        chk("gnt_writes", n_wr, 160);
        chk("gnt_reread37", n_rd_tgt, 2);
        chk("gnt_protocol", n_viol, 0);
        check_oam("gnt_data", 8'hC0);

        // Re-trigger at idx 50 with a new source page.
        do_reset();
        bus_gnt = 1'b1;
        fill_src(8'hC0);
        fill_src(8'hD0);
        write_reg(16'hFF46, 8'hC0);
        wait_wr(16'hFE32, 200, found);
        chk("retrig_reach_idx50", found, 1'b1);
        write_reg(16'hFF46, 8'hD0);
        chk("retrig_restart", {m_rd, m_addr}, {1'b1, 16'hD000});
        wait_done(400, done_at);
        tick();
        chk("retrig_done_count", n_done, 1);
        chk("retrig_protocol", n_viol, 0);
        check_oam("retrig_data", 8'hD0);

        // Asynchronous reset at idx 80.
        do_reset();
        bus_gnt = 1'b1;
        fill_src(8'hC0);
        write_reg(16'hFF46, 8'hC0);
        wait_wr(16'hFE50, 300, found);
        chk("rst_reach_idx80", found, 1'b1);
        reset = 1'b0;
        #1;
        chk("rst_async_outputs", {bus_req, busy, m_rd, m_wr, done}, 5'b0);
        chk("rst_async_addr", m_addr, 16'h0000);
        saved = n_wr;
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_no_more_writes", n_wr, saved);
        chk("rst_idle", {bus_req, busy}, 2'b00);
        reg_rd = 1'b1; reg_addr = 16'hFF46;
        tick();
        reg_rd = 1'b0;
        chk("rst_readback", {reg_hit, reg_rdata}, {1'b1, 8'hFF});

        // Randomized source page and random grant pattern.
        for (int t = 0; t < 6; t++) begin
            do_reset();
            hi = 8'($urandom_range(0, 253));
            fill_src(hi);
            bus_gnt = 1'($urandom_range(0, 1));
            write_reg(16'hFF46, hi);
            done_at = -1;
            for (int k = 0; k < 3000; k++) begin
                bus_gnt = ($urandom_range(0, 3) != 0);
                tick();
                if (done) begin done_at = cyc; break; end
            end
            bus_gnt = 1'b0;
            tick();
            chk($sformatf("rnd%0d_done_seen", t), done_at > 0, 1'b1);
            chk($sformatf("rnd%0d_writes", t), n_wr, 160);
            chk($sformatf("rnd%0d_out_of_range", t), n_wr_out, 0);
            chk($sformatf("rnd%0d_protocol", t), n_viol, 0);
            chk($sformatf("rnd%0d_done_count", t), n_done, 1);
            check_oam($sformatf("rnd%0d_data", t), hi);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
